// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle MIPS-subset datapath (R, LW, SW, BEQ, optional J).
// Sequences fetch/decode/execute/memory/writeback steps, stalls on MemReady,
// counts retired instructions and pulses IllegalOp on unsupported opcodes.
// Optional feature macro: JUMP_SUPPORT_EN (builds the J opcode / JUMP state).
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ALUOp0,
    output logic             ALUOp1,
    output logic [1:0]       PCSource,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADDR = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXEC    = 4'd6;
    localparam logic [3:0] RWB     = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
`ifdef JUMP_SUPPORT_EN
    localparam logic [3:0] JUMP    = 4'd9;
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    logic [3:0]       state_q, state_d;
    // Op is only valid in DECODE, so the LW/SW choice is remembered for MEMADDR.
    logic             is_load_q, is_load_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    // Moore outputs per state (plus the MemReady-qualified fetch strobes) and next-state logic
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp0      = 1'b0;
        ALUOp1      = 1'b0;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;
        retire      = 1'b0;
        state_d     = state_q;
        is_load_d   = is_load_q;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW:  begin state_d = MEMADDR; is_load_d = 1'b1; end
                    OP_SW:  begin state_d = MEMADDR; is_load_d = 1'b0; end
                    OP_R:   state_d = EXEC;
                    OP_BEQ: state_d = BRANCH;
`ifdef JUMP_SUPPORT_EN
                    OP_J:   state_d = JUMP;
`endif
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = is_load_q ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp0  = 1'b1;
                state_d = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp1      = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                state_d     = FETCH;
            end
`ifdef JUMP_SUPPORT_EN
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
                state_d  = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    assign PCEn       = PCWrite | (PCWriteCond & Zero);
    assign InstrCount = count_q;

    // State, load/store flag and retired-instruction counter; reset abandons any instruction
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= FETCH;
            is_load_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios followed by
// randomized instruction streams, checked cycle by cycle against a per-instruction
// reference schedule built from the opcode's step sequence and memory wait counts.
module tb_multicycle_control_fsm;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       PCEn;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemToReg;
        logic       RegWrite;
        logic       RegDst;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       ALUOp0;
        logic       ALUOp1;
        logic [1:0] PCSource;
        logic       IllegalOp;
    } ctl_t;

    logic             Clk, Reset, Zero, MemReady;
    logic [5:0]       Op;
    logic             PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic             MemToReg, RegWrite, RegDst, ALUSrcA, ALUOp0, ALUOp1, IllegalOp;
    logic [1:0]       ALUSrcB, PCSource;
    logic [CNT_W-1:0] InstrCount;

    int checks   = 0;
    int failures = 0;
    int retired  = 0;

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp0(ALUOp0), .ALUOp1(ALUOp1), .PCSource(PCSource), .IllegalOp(IllegalOp),
        .InstrCount(InstrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic rbit();
        return logic'($urandom & 1);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 illegal
    function automatic int kind_of(input logic [5:0] op);
        if (op == 6'b000000) return 0;
        if (op == 6'b100011) return 1;
        if (op == 6'b101011) return 2;
        if (op == 6'b000100) return 3;
`ifdef JUMP_SUPPORT_EN
        if (op == 6'b000010) return 4;
`endif
        return 5;
    endfunction

    function automatic ctl_t fetch_ctl(input logic rdy);
        ctl_t e = '0;
        e.MemRead = 1'b1;
        e.ALUSrcB = 2'b01;
        e.IRWrite = rdy;
        e.PCWrite = rdy;
        return e;
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare, then let the rising edge happen
    task automatic step(input logic rdy, input logic [5:0] op, input logic z,
                        input ctl_t exp, input logic ret, input string tag);
        ctl_t obs;
        logic [CNT_W-1:0] exp_cnt;
        @(negedge Clk);
        MemReady = rdy;
        Op       = op;
        Zero     = z;
        #2;
        exp.PCEn = exp.PCWrite | (exp.PCWriteCond & z);
        obs = {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp0, ALUOp1, PCSource, IllegalOp};
        exp_cnt = CNT_W'(retired % (1 << CNT_W));
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, obs, exp);
        end
        checks++;
        assert (InstrCount === exp_cnt) else begin
            failures++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, InstrCount, exp_cnt);
        end
        @(posedge Clk);
        if (ret) retired++;
    endtask

    // Full instruction: fw fetch wait cycles, mw memory wait cycles, z = ALU zero flag in BRANCH
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic z, input string tag);
        ctl_t e;
        int   k;
        k = kind_of(op);
        for (int i = 0; i < fw; i++) step(1'b0, rop(), rbit(), fetch_ctl(1'b0), 1'b0, {tag, "/fetchwait"});
        step(1'b1, rop(), rbit(), fetch_ctl(1'b1), 1'b0, {tag, "/fetch"});
        e = '0; e.ALUSrcB = 2'b11; e.IllegalOp = (k == 5);
        step(rbit(), op, rbit(), e, 1'b0, {tag, "/decode"});
        case (k)
            0: begin
                e = '0; e.ALUSrcA = 1'b1; e.ALUOp0 = 1'b1;
                step(rbit(), rop(), rbit(), e, 1'b0, {tag, "/exec"});
                e = '0; e.RegWrite = 1'b1; e.RegDst = 1'b1;
                step(rbit(), rop(), rbit(), e, 1'b1, {tag, "/rwb"});
            end
            1, 2: begin
                e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
                step(rbit(), rop(), rbit(), e, 1'b0, {tag, "/memaddr"});
                e = '0; e.IorD = 1'b1;
                if (k == 1) e.MemRead = 1'b1; else e.MemWrite = 1'b1;
                for (int i = 0; i < mw; i++) step(1'b0, rop(), rbit(), e, 1'b0, {tag, "/memwait"});
                step(1'b1, rop(), rbit(), e, (k == 2), {tag, "/mem"});
                if (k == 1) begin
                    e = '0; e.RegWrite = 1'b1; e.MemToReg = 1'b1;
                    step(rbit(), rop(), rbit(), e, 1'b1, {tag, "/memwb"});
                end
            end
            3: begin
                e = '0; e.ALUSrcA = 1'b1; e.ALUOp1 = 1'b1; e.PCWriteCond = 1'b1; e.PCSource = 2'b01;
                step(rbit(), rop(), z, e, 1'b1, {tag, "/branch"});
            end
            4: begin
                e = '0; e.PCWrite = 1'b1; e.PCSource = 2'b10;
                step(rbit(), rop(), rbit(), e, 1'b1, {tag, "/jump"});
            end
            default: ;
        endcase
    endtask

    task automatic do_reset(input int n);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (n) @(posedge Clk);
        #1 Reset = 1'b0;
        retired = 0;
    endtask

    initial begin
        ctl_t e;
        logic [5:0] op;
        Reset = 1'b1; MemReady = 1'b0; Op = '0; Zero = 1'b0;
        do_reset(2);

        // Directed scenarios
        run_instr(6'b000000, 0, 0, 1'b0, "r_basic");
        run_instr(6'b100011, 3, 2, 1'b0, "lw_waits");
        run_instr(6'b101011, 1, 1, 1'b0, "sw_waits");
        run_instr(6'b000100, 0, 0, 1'b1, "beq_taken");
        run_instr(6'b000100, 0, 0, 1'b0, "beq_nottaken");
        run_instr(6'b111111, 0, 0, 1'b0, "illegal");
        run_instr(6'b000010, 0, 0, 1'b0, "jump");

        // Counter wrap: 17 R-format instructions on a 4-bit counter
        do_reset(1);
        for (int i = 0; i < 17; i++) run_instr(6'b000000, 0, 0, 1'b0, "wrap_r");
        #1;
        checks++;
        assert (InstrCount === 4'd1) else begin
            failures++;
            $error("FAIL wrap17 count observed=%0d expected=1", InstrCount);
        end

        // Reset while waiting in the load memory read
        step(1'b1, rop(), rbit(), fetch_ctl(1'b1), 1'b0, "rst_mid/fetch");
        e = '0; e.ALUSrcB = 2'b11;
        step(1'b0, 6'b100011, rbit(), e, 1'b0, "rst_mid/decode");
        e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
        step(1'b0, rop(), rbit(), e, 1'b0, "rst_mid/memaddr");
        e = '0; e.IorD = 1'b1; e.MemRead = 1'b1;
        step(1'b0, rop(), rbit(), e, 1'b0, "rst_mid/memrd");
        do_reset(1);
        step(1'b0, rop(), rbit(), fetch_ctl(1'b0), 1'b0, "rst_mid/after");

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                default: op = rop();
            endcase
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rbit(), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style main control FSM for the multicycle MIPS-subset datapath: R-format, LW, SW, BEQ, plus optional J.
- Sequences one shared memory, ALU and register file across fetch, decode, execute, memory and writeback steps.
- Stalls on a memory-ready handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset. One clock; reset sampled only on the rising edge of Clk.
- Op  input  6  opcode from the instruction register (IR[31:26]).
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by Zero.
- PCEn  output  1  PCWrite | (PCWriteCond & Zero).
- IorD  output  1  0 selects PC as the memory address, 1 selects ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load instruction register.
- MemToReg  output  1  write-back data is MDR (1) or ALUOut (0).
- RegWrite  output  1  register file write.
- RegDst  output  1  destination is rd (1) or rt (0).
- ALUSrcA  output  1  ALU A is PC (0) or register A (1).
- ALUSrcB  output  2  00 B register, 01 constant 4, 10 sign-extended immediate, 11 shifted sign-extended immediate.
- ALUOp0  output  1  ALU uses the funct field (R-format).
- ALUOp1  output  1  ALU subtracts (BEQ). ALUOp0=ALUOp1=0 means add.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode.
- InstrCount  output  CNT_W  retired-instruction count.

Behaviour:
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010.
- State register encoding: FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP.
- Reset: state=FETCH, InstrCount=0, IllegalOp=0. Reset mid-instruction abandons it; no counter update.
- Every output not listed for a state is 0.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=add.
  - LW/SW go to MEMADDR; R goes to EXEC; BEQ goes to BRANCH; J goes to JUMP.
  - Any other opcode goes to FETCH with IllegalOp=1 for that cycle only.
- MEMADDR:
  - Asserts ALUSrcA=1, ALUSrcB=10, ALUOp=add.
  - LW goes to MEMRD; SW goes to MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp0=1. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp1=1, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- Latency with MemReady held at 1: R 4 cycles, LW 5, SW 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- InstrCount:
  - Increments by 1 on the last cycle of each instruction: MEMWB; MEMWR when MemReady=1; RWB; BRANCH (taken or not); JUMP.
  - Illegal opcodes do not count.
  - Wraps from 2^CNT_W-1 to 0 silently.
- Op is sampled only in DECODE. Changes on Op in other states have no effect.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro JUMP_SUPPORT_EN.
- Defined: J (000010) decodes to JUMP as above; PCSource=10 is reachable.
- Undefined: the JUMP state is not built; 000010 is treated as illegal (IllegalOp pulse in DECODE, return to FETCH, not counted); PCSource never equals 10.

Test Plan:
- Reset=1 for 2 cycles, then released → state FETCH, MemRead=1, InstrCount=0. With MemReady=1: IRWrite=PCWrite=1 in the first post-reset cycle.
- MemReady=1, Op=000000 → states FETCH, DECODE, EXEC, RWB. RegWrite=1 and RegDst=1 in cycle 4 only; InstrCount 0→1.
- Op=100011, MemReady=0 for 3 cycles in FETCH and 2 in MEMRD → total 10 cycles; MemToReg=RegWrite=1 only in MEMWB; InstrCount +1.
- Op=000100 with Zero=1, then with Zero=0 → PCEn=1 in BRANCH for the first and 0 for the second; both take 3 cycles and both increment InstrCount.
- Op=111111 → IllegalOp high for exactly the DECODE cycle, next state FETCH, InstrCount unchanged. Op=000010 → JUMP with PCSource=10 if JUMP_SUPPORT_EN is defined, IllegalOp otherwise.
- CNT_W=4: retire 17 R-format instructions → InstrCount reads 1. Assert Reset during MEMRD → next cycle FETCH, count 0.
